// File: rtl/alu_arbiter_32.sv
// Round-robin arbiter/sequencer sharing one alu_32 between two requesters.
// Holds the ALU operands for the op's occupancy time and registers the result.
module alu_arbiter_32 #(
  parameter int unsigned MUL_CYC = 4,
  parameter int unsigned DIV_CYC = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [4:0]  req0_fs,
  input  logic [31:0] req0_s,
  input  logic [31:0] req0_t,
  input  logic [4:0]  req0_sh,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [4:0]  req1_fs,
  input  logic [31:0] req1_s,
  input  logic [31:0] req1_t,
  input  logic [4:0]  req1_sh,
  output logic [4:0]  alu_fs,
  output logic [31:0] alu_s,
  output logic [31:0] alu_t,
  output logic [4:0]  alu_shift,
  input  logic [31:0] alu_y_hi,
  input  logic [31:0] alu_y_lo,
  input  logic [3:0]  alu_nzvc,
  output logic        rsp_valid,
  output logic        rsp_id,
  output logic [31:0] rsp_y_hi,
  output logic [31:0] rsp_y_lo,
  output logic [3:0]  rsp_nzvc,
  output logic        busy
);

  localparam logic [4:0] FS_MUL   = 5'h1E;
  localparam logic [4:0] FS_DIV   = 5'h1F;
  localparam logic [3:0] MUL_LOAD = 4'(MUL_CYC - 1);
  localparam logic [3:0] DIV_LOAD = 4'(DIV_CYC - 1);

  typedef enum logic {ST_IDLE = 1'b0, ST_EXEC = 1'b1} state_t;

  state_t      r_state;
  logic [3:0]  r_count;
  logic        r_last_grant;
  logic        r_op_id;
  logic [4:0]  r_alu_fs;
  logic [4:0]  r_alu_shift;
  logic [31:0] r_alu_s;
  logic [31:0] r_alu_t;
  logic        r_rsp_valid;
  logic        r_rsp_id;
  logic [31:0] r_rsp_y_hi;
  logic [31:0] r_rsp_y_lo;
  logic [3:0]  r_rsp_nzvc;
  logic        r_busy;

  logic        w_idle;
  logic        w_grant;
  logic        w_accept;
  logic [4:0]  w_fs;
  logic [4:0]  w_sh;
  logic [31:0] w_s;
  logic [31:0] w_t;
  logic [3:0]  w_load;

  // Ready is gated by reset so nothing is handed over while reset is held low.
  always_comb begin
    w_idle     = reset && (r_state == ST_IDLE);
    w_grant    = (req0_valid && req1_valid) ? ~r_last_grant : req1_valid;
    req0_ready = w_idle && req0_valid && !w_grant;
    req1_ready = w_idle && req1_valid && w_grant;
    w_accept   = req0_ready || req1_ready;
    w_fs       = w_grant ? req1_fs : req0_fs;
    w_s        = w_grant ? req1_s  : req0_s;
    w_t        = w_grant ? req1_t  : req0_t;
    w_sh       = w_grant ? req1_sh : req0_sh;
    if (w_fs == FS_MUL)      w_load = MUL_LOAD;
    else if (w_fs == FS_DIV) w_load = DIV_LOAD;
    else                     w_load = 4'd0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_count      <= 4'd0;
      r_last_grant <= 1'b1;
      r_op_id      <= 1'b0;
      r_alu_fs     <= 5'd0;
      r_alu_shift  <= 5'd0;
      r_alu_s      <= 32'd0;
      r_alu_t      <= 32'd0;
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= 1'b0;
      r_rsp_y_hi   <= 32'd0;
      r_rsp_y_lo   <= 32'd0;
      r_rsp_nzvc   <= 4'd0;
      r_busy       <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_alu_fs     <= w_fs;
            r_alu_s      <= w_s;
            r_alu_t      <= w_t;
            r_alu_shift  <= w_sh;
            r_op_id      <= w_grant;
            r_last_grant <= w_grant;
            r_count      <= w_load;
            r_busy       <= 1'b1;
            r_state      <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (r_count != 4'd0) begin
            r_count <= r_count - 4'd1;
          end else begin
            r_rsp_y_hi  <= alu_y_hi;
            r_rsp_y_lo  <= alu_y_lo;
            r_rsp_nzvc  <= alu_nzvc;
            r_rsp_id    <= r_op_id;
            r_rsp_valid <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign alu_fs    = r_alu_fs;
  assign alu_s     = r_alu_s;
  assign alu_t     = r_alu_t;
  assign alu_shift = r_alu_shift;
  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_y_hi  = r_rsp_y_hi;
  assign rsp_y_lo  = r_rsp_y_lo;
  assign rsp_nzvc  = r_rsp_nzvc;
  assign busy      = r_busy;

endmodule
